// File: rtl/watchdog_kicker_if.sv
`default_nettype none
// ============================================================================
// Module   : watchdog_kicker_if
// Brief    : Control, heartbeat and watchdog-side signals of the kicker.
// Revision : 1.0 - initial release
// ============================================================================
interface watchdog_kicker_if #(
    parameter int FCNT_W = 4
) ();
    logic              arm;
    logic              alive;
    logic              clr_fault;
    logic              timeout;
    logic              wd_enable;
    logic              wd_restart;
    logic              fault;
    logic [FCNT_W-1:0] fault_count;
    logic [1:0]        state;

    // master is the kicker itself; slave is the supervised logic plus watchdog
    modport master (
        input  arm, alive, clr_fault, timeout,
        output wd_enable, wd_restart, fault, fault_count, state
    );
    modport slave (
        output arm, alive, clr_fault, timeout,
        input  wd_enable, wd_restart, fault, fault_count, state
    );
endinterface
`default_nettype wire

// File: rtl/watchdog_kicker.sv
`default_nettype none
// ============================================================================
// Module   : watchdog_kicker
// Brief    : Kicks an external watchdog while a supervised task stays alive,
//            withholds kicks when it goes silent, and latches/counts faults.
// Revision : 1.0 - initial release
// ============================================================================
module watchdog_kicker #(
    parameter int KICK_PERIOD  = 8,
    parameter int ALIVE_WINDOW = 12,
    parameter int FCNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    watchdog_kicker_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STARVE = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    localparam logic [3:0]        C_KICK_LAST  = 4'(KICK_PERIOD - 1);
    localparam logic [7:0]        C_ALIVE_LAST = 8'(ALIVE_WINDOW - 1);
    localparam logic [FCNT_W-1:0] C_FCNT_MAX   = '1;
    localparam logic [FCNT_W-1:0] C_FCNT_ONE   = FCNT_W'(1);

    state_t            state_q, state_d;
    logic [3:0]        kick_cnt_q, kick_cnt_d;
    logic [7:0]        alive_cnt_q, alive_cnt_d;
    logic [FCNT_W-1:0] fault_count_q, fault_count_d;
    logic              wd_enable_q, wd_enable_d;
    logic              wd_restart_q, wd_restart_d;
    logic              fault_q, fault_d;
    logic              starve;

    always_comb begin
        state_d       = state_q;
        kick_cnt_d    = kick_cnt_q;
        alive_cnt_d   = alive_cnt_q;
        fault_count_d = fault_count_q;
        starve        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.arm) begin
                    state_d     = ST_ARMED;
                    kick_cnt_d  = 4'd0;
                    alive_cnt_d = 8'd0;
                end
            end
            ST_ARMED: begin
                starve = !bus.alive && (alive_cnt_q == C_ALIVE_LAST);
                if (bus.timeout) begin
                    state_d = ST_FAULT;
                end else if (!bus.arm) begin
                    state_d = ST_IDLE;
                end else if (starve) begin
                    state_d = ST_STARVE;
                end else begin
                    kick_cnt_d  = (kick_cnt_q == C_KICK_LAST) ? 4'd0 : kick_cnt_q + 4'd1;
                    alive_cnt_d = bus.alive ? 8'd0 : alive_cnt_q + 8'd1;
                end
            end
            ST_STARVE: begin
                if (bus.timeout) begin
                    state_d = ST_FAULT;
                end else if (!bus.arm) begin
                    state_d = ST_IDLE;
                end else if (bus.alive) begin
                    state_d     = ST_ARMED;
                    kick_cnt_d  = 4'd0;
                    alive_cnt_d = 8'd0;
                end
            end
            ST_FAULT: begin
                if (bus.clr_fault) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d == ST_FAULT) && (state_q != ST_FAULT) && (fault_count_q != C_FCNT_MAX)) begin
            fault_count_d = fault_count_q + C_FCNT_ONE;
        end

        // Outputs are registered, so they are derived from the next state
        wd_enable_d  = (state_d == ST_ARMED) || (state_d == ST_STARVE);
        wd_restart_d = (state_d == ST_ARMED) && (kick_cnt_d == 4'd0);
        fault_d      = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            kick_cnt_q    <= 4'd0;
            alive_cnt_q   <= 8'd0;
            fault_count_q <= '0;
            wd_enable_q   <= 1'b0;
            wd_restart_q  <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            kick_cnt_q    <= kick_cnt_d;
            alive_cnt_q   <= alive_cnt_d;
            fault_count_q <= fault_count_d;
            wd_enable_q   <= wd_enable_d;
            wd_restart_q  <= wd_restart_d;
            fault_q       <= fault_d;
        end
    end

    assign bus.wd_enable   = wd_enable_q;
    assign bus.wd_restart  = wd_restart_q;
    assign bus.fault       = fault_q;
    assign bus.fault_count = fault_count_q;
    assign bus.state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_watchdog_kicker.sv
`default_nettype none
// ============================================================================
// Module   : tb_watchdog_kicker
// Brief    : Closed-loop bench: watchdog model, reference model, random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_watchdog_kicker;

    localparam int KP  = 8;
    localparam int AW  = 12;
    localparam int FW  = 4;

    logic clk;
    logic rst_n;
    logic force_to;
    logic wd_to;
    int   wcnt;
    int   n_checks;
    int   n_errors;

    watchdog_kicker_if #(.FCNT_W(FW)) bus ();

    watchdog_kicker #(
        .KICK_PERIOD (KP),
        .ALIVE_WINDOW(AW),
        .FCNT_W      (FW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 4-bit watchdog: fires once 15 cycles have passed since its last restart
    initial begin
        wcnt  = 0;
        wd_to = 1'b0;
    end
    always @(negedge clk) begin
        if (bus.wd_enable !== 1'b1 || bus.wd_restart === 1'b1) wcnt = 0;
        else if (wcnt < 15) wcnt = wcnt + 1;
        wd_to = (bus.wd_enable === 1'b1) && (wcnt == 15);
    end
    assign bus.timeout = wd_to | force_to;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks = n_checks + 1;
        if (act !== exp_v) begin
            n_errors = n_errors + 1;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
        end
    endtask

    // Reference model: mode 0..3 = idle/armed/starve/fault, age = cycles since
    // entering ARMED, silent = consecutive cycles without alive in ARMED.
    int m_mode, m_age, m_silent, m_fcnt;
    initial begin
        m_mode = 0; m_age = 0; m_silent = 0; m_fcnt = 0;
    end

    task automatic model_step();
        bit to_fault, to_idle, to_armed;
        to_fault = 0; to_idle = 0; to_armed = 0;
        if (!rst_n) begin
            m_mode = 0; m_age = 0; m_silent = 0; m_fcnt = 0;
            return;
        end
        case (m_mode)
            0: to_armed = bus.arm;
            1: begin
                if (bus.timeout) to_fault = 1;
                else if (!bus.arm) to_idle = 1;
                else if (!bus.alive && m_silent == AW - 1) m_mode = 2;
                else begin
                    m_age    = m_age + 1;
                    m_silent = bus.alive ? 0 : m_silent + 1;
                end
            end
            2: begin
                if (bus.timeout) to_fault = 1;
                else if (!bus.arm) to_idle = 1;
                else if (bus.alive) to_armed = 1;
            end
            default: if (bus.clr_fault) to_idle = 1;
        endcase
        if (to_fault) begin
            m_mode = 3;
            if (m_fcnt < (1 << FW) - 1) m_fcnt = m_fcnt + 1;
        end
        if (to_idle) m_mode = 0;
        if (to_armed) begin
            m_mode = 1; m_age = 0; m_silent = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        chk("state",       8'(bus.state),       8'(m_mode));
        chk("wd_enable",   8'(bus.wd_enable),   8'(m_mode == 1 || m_mode == 2));
        chk("wd_restart",  8'(bus.wd_restart),  8'(m_mode == 1 && (m_age % KP) == 0));
        chk("fault",       8'(bus.fault),       8'(m_mode == 3));
        chk("fault_count", 8'(bus.fault_count), 8'(m_fcnt));
    end

    task automatic wait_state(input logic [1:0] tgt, input int budget, input string nm);
        for (int k = 0; k < budget && bus.state !== tgt; k++) @(negedge clk);
        chk(nm, 8'(bus.state), 8'(tgt));
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; force_to = 1'b0;
        bus.arm = 1'b0; bus.alive = 1'b0; bus.clr_fault = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", 8'(bus.state), 8'd0);
        chk("rst_enable", 8'(bus.wd_enable), 8'd0);
        chk("rst_fcnt", 8'(bus.fault_count), 8'd0);

        // Arm with a steady heartbeat: kicks every KP cycles, never a fault
        rst_n = 1'b1; bus.arm = 1'b1;
        @(negedge clk);
        chk("arm_state", 8'(bus.state), 8'd1);
        chk("arm_enable", 8'(bus.wd_enable), 8'd1);
        chk("arm_first_kick", 8'(bus.wd_restart), 8'd1);
        for (int i = 0; i < 100; i++) begin
            bus.alive = (i % 5 == 0);
            @(negedge clk);
            if (i + 1 == 8)  chk("kick_at_8", 8'(bus.wd_restart), 8'd1);
            if (i + 1 == 9)  chk("nokick_at_9", 8'(bus.wd_restart), 8'd0);
            if (i + 1 == 16) chk("kick_at_16", 8'(bus.wd_restart), 8'd1);
        end
        chk("hb_no_fault", 8'(bus.fault), 8'd0);
        chk("hb_fcnt", 8'(bus.fault_count), 8'd0);

        // Heartbeat stops: starve, then the watchdog fires
        bus.alive = 1'b0;
        wait_state(2'd2, 20, "starve_entry");
        wait_state(2'd3, 20, "starve_to_fault");
        chk("fault1_fcnt", 8'(bus.fault_count), 8'd1);
        chk("fault1_enable", 8'(bus.wd_enable), 8'd0);

        // FAULT is sticky regardless of arm until clr_fault
        for (int i = 0; i < 6; i++) begin
            bus.arm = i[0];
            @(negedge clk);
            chk("fault_sticky", 8'(bus.state), 8'd3);
        end
        bus.arm = 1'b1; bus.clr_fault = 1'b1;
        @(negedge clk);
        bus.clr_fault = 1'b0;
        chk("clr_to_idle", 8'(bus.state), 8'd0);
        chk("clr_fault_low", 8'(bus.fault), 8'd0);
        @(negedge clk);
        chk("rearm_state", 8'(bus.state), 8'd1);
        chk("rearm_kick", 8'(bus.wd_restart), 8'd1);

        // Recovery from STARVE before the watchdog fires
        wait_state(2'd2, 20, "starve2_entry");
        repeat (2) @(negedge clk);
        bus.alive = 1'b1;
        @(negedge clk);
        bus.alive = 1'b0;
        chk("recover_state", 8'(bus.state), 8'd1);
        chk("recover_kick", 8'(bus.wd_restart), 8'd1);
        chk("recover_fcnt", 8'(bus.fault_count), 8'd1);

        // timeout and alive together in STARVE: FAULT wins
        wait_state(2'd2, 20, "starve3_entry");
        force_to = 1'b1; bus.alive = 1'b1;
        @(negedge clk);
        force_to = 1'b0; bus.alive = 1'b0;
        chk("tie_fault", 8'(bus.state), 8'd3);
        chk("tie_fcnt", 8'(bus.fault_count), 8'd2);
        bus.arm = 1'b0; bus.clr_fault = 1'b1;
        @(negedge clk);
        bus.clr_fault = 1'b0;

        // Randomized segments with varying heartbeat density
        for (int seg = 0; seg < 20; seg++) begin
            int p;
            case ($urandom_range(3, 0))
                0: p = 0;
                1: p = 6;
                2: p = 25;
                default: p = 70;
            endcase
            for (int c = 0; c < 200; c++) begin
                rst_n         = ($urandom_range(499, 0) != 0);
                bus.arm       = ($urandom_range(63, 0) != 0);
                bus.alive     = ($urandom_range(99, 0) < p);
                bus.clr_fault = ($urandom_range(7, 0) == 0);
                force_to      = ($urandom_range(96, 0) == 0);
                @(negedge clk);
            end
        end

        // Saturation of fault_count, then reset mid-FAULT
        rst_n = 1'b0; bus.arm = 1'b0; bus.alive = 1'b0; bus.clr_fault = 1'b0; force_to = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("sat_start_fcnt", 8'(bus.fault_count), 8'd0);
        for (int f = 0; f < 17; f++) begin
            if (f > 0) begin
                bus.clr_fault = 1'b1; bus.arm = 1'b0;
                @(negedge clk);
                bus.clr_fault = 1'b0;
            end
            bus.arm = 1'b1;
            @(negedge clk);
            force_to = 1'b1;
            @(negedge clk);
            force_to = 1'b0;
            if (f == 14) chk("fcnt_at_15", 8'(bus.fault_count), 8'd15);
        end
        chk("fcnt_saturated", 8'(bus.fault_count), 8'd15);
        chk("sat_in_fault", 8'(bus.state), 8'd3);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; bus.arm = 1'b0;
        chk("midfault_rst_state", 8'(bus.state), 8'd0);
        chk("midfault_rst_fault", 8'(bus.fault), 8'd0);
        chk("midfault_rst_fcnt", 8'(bus.fault_count), 8'd0);
        chk("midfault_rst_enable", 8'(bus.wd_enable), 8'd0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
